input_loader: RTL and testbench
===============================

// Module: input_loader
// PURPOSE
//  Fill stage directly upstream of the matrix controller. While the controller holds
//  input_load_en, this block shifts in the 32-element X matrix (8 rows x 4 cols) from a
//  valid/ready stream and fetches the 32 A coefficients from the coefficient ROM.
//  It reports xload_done / aload_done back to the controller.
//  It serves both stored matrices to the ALU through asynchronous read ports.
// PARAMETERS
//  DATA_W   8   width of one X element
//  COEF_W   7   width of one A coefficient (ROM word)
//  DEPTH   32   elements per matrix (X and A each)
//  ADDR_W   5   log2(DEPTH)
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  rst            in   1       asynchronous reset, active-high
//  input_load_en  in   1       load window from controller; rising edge starts a load
//  x_valid        in   1       X stream element valid
//  x_data         in   DATA_W  X stream element, row-major (idx = row*4+col)
//  x_ready        out  1       block accepts X element this cycle
//  rom_rd         out  1       coefficient ROM read strobe
//  rom_addr       out  ADDR_W  coefficient ROM address
//  rom_data       in   COEF_W  ROM read data, valid exactly 1 cycle after rom_rd
//  xload_done     out  1       all DEPTH X elements stored (level)
//  aload_done     out  1       all DEPTH A coefficients stored (level)
//  x_rd_addr      in   ADDR_W  ALU read address, X store
//  x_rd_data      out  DATA_W  X store contents, combinational from x_rd_addr
//  a_rd_addr      in   ADDR_W  ALU read address, A store
//  a_rd_data      out  COEF_W  A store contents, combinational from a_rd_addr
// BEHAVIOUR
//  Reset (rst=1, async)
//   - x_ready, rom_rd, xload_done, aload_done = 0; rom_addr = 0.
//   - Both FSMs go to IDLE; counters = 0; en_q = 0.
//   - Stores are not cleared; read ports return stale data.
//  Start detect
//   - start = input_load_en & ~en_q, where en_q is input_load_en registered.
//   - Both FSMs run independently and concurrently.
//  X FSM: X_IDLE -> X_LOAD -> X_DONE
//   - X_IDLE: x_ready = 0; x_valid ignored. On start: -> X_LOAD, x_cnt = 0.
//   - X_LOAD: x_ready = 1. Each cycle with x_valid & x_ready:
//     x_mem[x_cnt] <= x_data; x_cnt += 1.
//   - The accept at x_cnt = DEPTH-1 -> X_DONE. xload_done = 1 from the next cycle (registered).
//   - X_DONE: x_ready = 0; xload_done held 1 while input_load_en = 1.
//   - x_valid while x_ready = 0: ignored, no write, no count.
//  A FSM: A_IDLE -> A_FETCH -> A_DRAIN -> A_DONE
//   - A_IDLE: On start: -> A_FETCH, a_cnt = 0.
//   - A_FETCH: rom_rd = 1, rom_addr = a_cnt, a_cnt += 1 every cycle (no stalls).
//     Issuing address DEPTH-1 -> A_DRAIN.
//   - Every cycle after a rom_rd: a_mem[addr_q] <= rom_data (addr_q = last issued address).
//   - A_DRAIN: rom_rd = 0; captures the last word -> A_DONE.
//   - A_DONE: aload_done = 1, held while input_load_en = 1.
//   - Latency: first rom_rd in the cycle after start is sampled. aload_done rises DEPTH+1
//     cycles after the first rom_rd (33 for DEPTH=32).
//  Release / abort
//   - input_load_en sampled 0 in any non-IDLE state: both FSMs -> IDLE the next cycle.
//     Done flags, x_ready and rom_rd drop in that same transition.
//   - A partial load (abort) leaves partial store contents; a later start restarts from index 0.
//   - A new start requires input_load_en low for at least 1 cycle.
//  Counters
//   - Counters are ADDR_W bits. Wrap to 0 is never observable, because the FSM leaves the
//     load state on the last index.
//  Simultaneous events
//   - start while rst = 1: rst wins.
//   - Abort in the cycle of the final X accept or the final ROM capture: the write still
//     completes, but the done flag is not raised.
//  Read ports
//   - Purely combinational, independent of FSM state.
//   - Reads of an address written in the same cycle return the old value.
// TESTING
//  1 rst=1 mid-load (X at idx 10, A at idx 20) -> all outputs 0 next edge; re-load from idx 0 completes.
//  2 en rises, x_valid=1 every cycle, data=idx+1 -> xload_done high 33 cycles after start; x_rd_addr=31 reads 32.
//  3 ROM model rom_data=addr^7'h55 -> rom_rd high 32 cycles, addrs 0..31; aload_done rises 33 cycles after first rom_rd; a_rd_addr=5 reads 7'h50.
//  4 x_valid toggling 1/0, plus pulses while x_ready=0 -> exactly 32 writes; stored values match accepted order.
//  5 en drops at X idx 12 -> xload_done never rises, x_ready=0 next cycle; en re-raised -> fresh 32-element load.
//  6 en held high after both done -> flags stay 1, rom_rd stays 0; en low -> flags 0 the next cycle.

Source files
------------

// File: rtl/input_loader.sv
// input_loader: fill stage ahead of the matrix controller.
// While input_load_en is held, it streams 32 X elements in over valid/ready and
// fetches 32 A coefficients from the coefficient ROM. The two loads run
// concurrently. Both stores are served to the ALU through combinational read
// ports.
module input_loader #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 7,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              input_load_en,
  input  logic              x_valid,
  input  logic [DATA_W-1:0] x_data,
  output logic              x_ready,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COEF_W-1:0] rom_data,
  output logic              xload_done,
  output logic              aload_done,
  input  logic [ADDR_W-1:0] x_rd_addr,
  output logic [DATA_W-1:0] x_rd_data,
  input  logic [ADDR_W-1:0] a_rd_addr,
  output logic [COEF_W-1:0] a_rd_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {X_IDLE, X_LOAD, X_DONE} x_state_t;
  typedef enum logic [1:0] {A_IDLE, A_FETCH, A_DRAIN, A_DONE} a_state_t;

  x_state_t          r_x_state;
  a_state_t          r_a_state;
  logic              r_en_q;
  logic [ADDR_W-1:0] r_x_cnt;
  logic [ADDR_W-1:0] r_a_cnt;
  logic              r_x_ready;
  logic              r_rom_rd;
  logic              r_xload_done;
  logic              r_aload_done;
  logic              r_cap_vld;
  logic [ADDR_W-1:0] r_cap_addr;

  logic [DATA_W-1:0] r_x_mem [DEPTH];
  logic [COEF_W-1:0] r_a_mem [DEPTH];

  logic w_start;
  logic w_x_accept;

  // A load begins only on the rising edge of the controller's load window.
  assign w_start    = input_load_en & ~r_en_q;
  // x_ready is only ever high in X_LOAD, so it doubles as the state qualifier.
  assign w_x_accept = r_x_ready & x_valid;

  // Register the load window so its rising edge can be detected.
  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_en_q <= 1'b0;
    else     r_en_q <= input_load_en;
  end

  // X stream FSM: accept DEPTH elements, then hold done until the window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x_state    <= X_IDLE;
      r_x_cnt      <= '0;
      r_x_ready    <= 1'b0;
      r_xload_done <= 1'b0;
    end else begin
      case (r_x_state)
        X_IDLE: begin
          if (w_start) begin
            r_x_state <= X_LOAD;
            r_x_cnt   <= '0;
            r_x_ready <= 1'b1;
          end
        end
        X_LOAD: begin
          if (!input_load_en) begin
            // Abort: a final accept in this cycle is still written, but done stays low.
            r_x_state <= X_IDLE;
            r_x_ready <= 1'b0;
          end else if (w_x_accept) begin
            r_x_cnt <= r_x_cnt + 1'b1;
            if (r_x_cnt == LAST_IDX) begin
              r_x_state    <= X_DONE;
              r_x_ready    <= 1'b0;
              r_xload_done <= 1'b1;
            end
          end
        end
        X_DONE: begin
          if (!input_load_en) begin
            r_x_state    <= X_IDLE;
            r_xload_done <= 1'b0;
          end
        end
        default: begin
          r_x_state    <= X_IDLE;
          r_x_ready    <= 1'b0;
          r_xload_done <= 1'b0;
        end
      endcase
    end
  end

  // A fetch FSM: issue DEPTH back-to-back ROM reads, drain the last word, then hold done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_state    <= A_IDLE;
      r_a_cnt      <= '0;
      r_rom_rd     <= 1'b0;
      r_aload_done <= 1'b0;
    end else begin
      case (r_a_state)
        A_IDLE: begin
          if (w_start) begin
            r_a_state <= A_FETCH;
            r_a_cnt   <= '0;
            r_rom_rd  <= 1'b1;
          end
        end
        A_FETCH: begin
          if (!input_load_en) begin
            r_a_state <= A_IDLE;
            r_rom_rd  <= 1'b0;
          end else if (r_a_cnt == LAST_IDX) begin
            r_a_state <= A_DRAIN;
            r_rom_rd  <= 1'b0;
          end else begin
            r_a_cnt <= r_a_cnt + 1'b1;
          end
        end
        A_DRAIN: begin
          if (!input_load_en) begin
            r_a_state <= A_IDLE;
          end else begin
            r_a_state    <= A_DONE;
            r_aload_done <= 1'b1;
          end
        end
        A_DONE: begin
          if (!input_load_en) begin
            r_a_state    <= A_IDLE;
            r_aload_done <= 1'b0;
          end
        end
        default: begin
          r_a_state    <= A_IDLE;
          r_rom_rd     <= 1'b0;
          r_aload_done <= 1'b0;
        end
      endcase
    end
  end

  // Track which ROM address was issued last cycle; its data arrives this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld  <= 1'b0;
      r_cap_addr <= '0;
    end else begin
      r_cap_vld  <= r_rom_rd;
      r_cap_addr <= r_a_cnt;
    end
  end

  // Store writes; captures complete even if the window closes in the same cycle.
  // NOTE: the stores have no reset; their contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (w_x_accept) r_x_mem[r_x_cnt] <= x_data;
    if (r_cap_vld)  r_a_mem[r_cap_addr] <= rom_data;
  end

  assign x_ready    = r_x_ready;
  assign rom_rd     = r_rom_rd;
  assign rom_addr   = r_a_cnt;
  assign xload_done = r_xload_done;
  assign aload_done = r_aload_done;
  assign x_rd_data  = r_x_mem[x_rd_addr];
  assign a_rd_data  = r_a_mem[a_rd_addr];

endmodule

// File: tb/tb_input_loader.sv
// Directed bench for input_loader: reset, full loads, ROM fetch timing, stalled
// stream, abort/restart, done hold/release and reset in the middle of a load.
module tb_input_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       input_load_en = 1'b0;
  logic       x_valid = 1'b0;
  logic [7:0] x_data = 8'h00;
  logic       x_ready;
  logic       rom_rd;
  logic [4:0] rom_addr;
  logic [6:0] rom_data = 7'h00;
  logic       xload_done;
  logic       aload_done;
  logic [4:0] x_rd_addr = 5'd0;
  logic [7:0] x_rd_data;
  logic [4:0] a_rd_addr = 5'd0;
  logic [6:0] a_rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  input_loader dut (
    .clk           (clk),
    .rst           (rst),
    .input_load_en (input_load_en),
    .x_valid       (x_valid),
    .x_data        (x_data),
    .x_ready       (x_ready),
    .rom_rd        (rom_rd),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .xload_done    (xload_done),
    .aload_done    (aload_done),
    .x_rd_addr     (x_rd_addr),
    .x_rd_data     (x_rd_data),
    .a_rd_addr     (a_rd_addr),
    .a_rd_data     (a_rd_data)
  );

  always #5 clk = ~clk;

  // ROM model: data valid exactly one cycle after the strobe, junk otherwise.
  always @(posedge clk) rom_data <= rom_rd ? (7'(rom_addr) ^ 7'h55) : 7'h7F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rd_x(input logic [4:0] addr, input logic [7:0] exp, input string tag);
    x_rd_addr = addr;
    #1;
    check(tag, 32'(x_rd_data), 32'(exp));
  endtask

  task automatic rd_a(input logic [4:0] addr, input logic [6:0] exp, input string tag);
    a_rd_addr = addr;
    #1;
    check(tag, 32'(a_rd_data), 32'(exp));
  endtask

  // Called at a negedge with the load window low at the previous edge.
  // Raises the window, streams base+idx every cycle, and checks done timing.
  // Returns at the negedge of the cycle where aload_done is first high.
  task automatic full_load(input logic [7:0] base, input string tag);
    int rom_ok;
    rom_ok        = 0;
    input_load_en = 1'b1;
    x_valid       = 1'b1;
    x_data        = 8'hEE;  // sampled while x_ready is still 0: must be ignored
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (rom_rd === 1'b1 && rom_addr === 5'(i - 1)) rom_ok++;
      x_data = base + 8'(i - 1);
      if (i == 1)  check({tag, "_xready_first"}, 32'(x_ready), 1);
      if (i == 32) check({tag, "_xdone_early"}, 32'(xload_done), 0);
    end
    @(negedge clk);
    x_valid = 1'b0;
    check({tag, "_xdone_c33"}, 32'(xload_done), 1);
    check({tag, "_xready_off"}, 32'(x_ready), 0);
    check({tag, "_romrd_off"}, 32'(rom_rd), 0);
    check({tag, "_adone_early"}, 32'(aload_done), 0);
    check({tag, "_rom_seq"}, 32'(rom_ok), 32);
    @(negedge clk);
    check({tag, "_adone_c34"}, 32'(aload_done), 1);
    check({tag, "_xdone_hold"}, 32'(xload_done), 1);
  endtask

  initial begin
    int k;
    int mism;
    logic prev_acc;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_xready", 32'(x_ready), 0);
    check("rst_romrd", 32'(rom_rd), 0);
    check("rst_romaddr", 32'(rom_addr), 0);
    check("rst_xdone", 32'(xload_done), 0);
    check("rst_adone", 32'(aload_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Full load: X data = idx+1, A data = addr ^ 0x55
    full_load(8'h01, "t2");
    rd_x(5'd31, 8'd32, "t2_x31");
    rd_x(5'd0, 8'd1, "t2_x0");
    rd_a(5'd5, 7'h50, "t3_a5");
    rd_a(5'd0, 7'h55, "t3_a0");
    rd_a(5'd31, 7'h4A, "t3_a31");

    // Hold the window after both done, then release
    repeat (6) @(negedge clk);
    check("t6_xdone_held", 32'(xload_done), 1);
    check("t6_adone_held", 32'(aload_done), 1);
    check("t6_romrd_quiet", 32'(rom_rd), 0);
    input_load_en = 1'b0;
    check("t6_xdone_same_cycle", 32'(xload_done), 1);
    @(negedge clk);
    check("t6_xdone_drop", 32'(xload_done), 0);
    check("t6_adone_drop", 32'(aload_done), 0);

    // Stalled stream: x_valid toggles, data = k*3+100 per accepted element
    input_load_en = 1'b1;
    x_valid       = 1'b1;
    x_data        = 8'hEE;
    k        = 0;
    mism     = 0;
    prev_acc = 1'b0;
    for (int c = 0; c < 200 && k < 32; c++) begin
      @(negedge clk);
      if (prev_acc) k++;
      if (xload_done !== (k == 32)) mism++;
      x_valid  = (c % 2 == 0);
      x_data   = x_valid ? 8'(k * 3 + 100) : 8'h11;
      prev_acc = x_valid & x_ready;
    end
    check("t4_budget", 32'(k), 32);
    check("t4_done_timing", 32'(mism), 0);
    // Pulses while x_ready is low must not write
    for (int c = 0; c < 3; c++) begin
      x_valid = 1'b1;
      x_data  = 8'hFF;
      @(negedge clk);
      check("t4_xready_low", 32'(x_ready), 0);
    end
    x_valid = 1'b0;
    for (int i = 0; i < 32; i++) rd_x(5'(i), 8'(i * 3 + 100), $sformatf("t4_x%0d", i));
    input_load_en = 1'b0;
    @(negedge clk);
    check("t4_release", 32'(xload_done), 0);

    // Abort at X index 12, then a fresh full load
    input_load_en = 1'b1;
    x_valid       = 1'b1;
    x_data        = 8'hEE;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      x_data = 8'h40 + 8'(i - 1);
    end
    @(negedge clk);
    input_load_en = 1'b0;
    x_valid       = 1'b0;
    check("t5_xready_before", 32'(x_ready), 1);
    @(negedge clk);
    check("t5_xready_abort", 32'(x_ready), 0);
    check("t5_romrd_abort", 32'(rom_rd), 0);
    check("t5_xdone_abort", 32'(xload_done), 0);
    check("t5_adone_abort", 32'(aload_done), 0);
    repeat (3) @(negedge clk);
    check("t5_xdone_stays", 32'(xload_done), 0);
    rd_x(5'd0, 8'h40, "t5_x0");
    rd_x(5'd11, 8'h4B, "t5_x11");
    rd_x(5'd12, 8'd136, "t5_x12_stale");
    full_load(8'h80, "t5r");
    rd_x(5'd0, 8'h80, "t5r_x0");
    rd_x(5'd12, 8'h8C, "t5r_x12");
    rd_x(5'd31, 8'h9F, "t5r_x31");
    input_load_en = 1'b0;
    @(negedge clk);

    // Reset mid-load: X at index 10, A at index 20
    input_load_en = 1'b1;
    x_valid       = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      x_valid = 1'b1;
      x_data  = 8'h30 + 8'(i);
    end
    @(negedge clk);
    x_valid = 1'b0;
    check("t1_romaddr_mid", 32'(rom_addr), 20);
    check("t1_xready_mid", 32'(x_ready), 1);
    rst           = 1'b1;
    input_load_en = 1'b0;
    #1;
    check("t1_xready_rst", 32'(x_ready), 0);
    check("t1_romrd_rst", 32'(rom_rd), 0);
    check("t1_romaddr_rst", 32'(rom_addr), 0);
    check("t1_xdone_rst", 32'(xload_done), 0);
    check("t1_adone_rst", 32'(aload_done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_x(5'd3, 8'h33, "t1_x3_stale");
    @(negedge clk);
    full_load(8'hC0, "t1r");
    rd_x(5'd0, 8'hC0, "t1r_x0");
    rd_x(5'd10, 8'hCA, "t1r_x10");
    rd_a(5'd20, 7'h41, "t1r_a20");
    input_load_en = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
